// File: rtl/zap_wb_arbiter.sv
// Round-robin Wishbone arbiter: NUM_MASTERS requesters share one bus, with no preemption.
// Define ZAP_WB_ARBITER_TIMEOUT_EN to add the stalled-strobe watchdog (bus error plus requester mask).
module zap_wb_arbiter #(
  parameter int unsigned NUM_MASTERS    = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                      i_clk,
  input  logic                      i_reset_n,
  input  logic [NUM_MASTERS-1:0]    i_m_cyc,
  input  logic [NUM_MASTERS-1:0]    i_m_stb,
  input  logic [NUM_MASTERS-1:0]    i_m_wen,
  input  logic [4*NUM_MASTERS-1:0]  i_m_sel,
  input  logic [32*NUM_MASTERS-1:0] i_m_adr,
  input  logic [32*NUM_MASTERS-1:0] i_m_dat,
  input  logic [3*NUM_MASTERS-1:0]  i_m_cti,
  output logic [NUM_MASTERS-1:0]    o_m_ack,
  output logic [NUM_MASTERS-1:0]    o_m_err,
  output logic [31:0]               o_m_dat,
  output logic                      o_wb_cyc,
  output logic                      o_wb_stb,
  output logic                      o_wb_wen,
  output logic [3:0]                o_wb_sel,
  output logic [31:0]               o_wb_adr,
  output logic [31:0]               o_wb_dat,
  output logic [2:0]                o_wb_cti,
  input  logic [31:0]               i_wb_dat,
  input  logic                      i_wb_ack,
  output logic [NUM_MASTERS-1:0]    o_grant
);

  localparam int unsigned IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  typedef enum logic {IDLE, OWN} state_t;

  state_t                 r_state, w_state_nx;
  logic [NUM_MASTERS-1:0] r_grant;
  logic [IW-1:0]          r_gidx;
  logic [IW-1:0]          r_last;
  logic [NUM_MASTERS-1:0] w_req;
  logic                   w_found;
  logic [IW-1:0]          w_nidx;
  int unsigned            w_k;
  logic                   w_timeout;
  logic                   w_cyc_g;

`ifdef ZAP_WB_ARBITER_TIMEOUT_EN
  logic [15:0]            r_tmo;
  logic [NUM_MASTERS-1:0] r_mask;

  assign w_timeout = (r_state == OWN) && o_wb_stb && !i_wb_ack &&
                     (r_tmo == 16'(TIMEOUT_CYCLES - 1));
  assign w_req     = i_m_cyc & ~r_mask;
  assign o_m_err   = w_timeout ? r_grant : '0;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_tmo  <= '0;
      r_mask <= '0;
    end else begin
      if (r_state != OWN || i_wb_ack || w_timeout)
        r_tmo <= '0;
      else if (o_wb_stb)
        r_tmo <= r_tmo + 16'd1;
      // A timed-out master stays masked until it lets go of cyc.
      r_mask <= (r_mask | (w_timeout ? r_grant : '0)) & i_m_cyc;
    end
  end
`else
  assign w_timeout = 1'b0;
  assign w_req     = i_m_cyc;
  assign o_m_err   = '0;
`endif

  // Round-robin scan starting just above the last granted master.
  always_comb begin
    w_found = 1'b0;
    w_nidx  = '0;
    w_k     = 0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      w_k = (32'(r_last) + 1 + i) % NUM_MASTERS;
      if (!w_found && w_req[w_k]) begin
        w_found = 1'b1;
        w_nidx  = IW'(w_k);
      end
    end
  end

  assign w_cyc_g = i_m_cyc[r_gidx];

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      IDLE:    if (w_found) w_state_nx = OWN;
      OWN:     if (!w_cyc_g || w_timeout) w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_gidx  <= '0;
      r_last  <= IW'(NUM_MASTERS - 1);
    end else begin
      r_state <= w_state_nx;
      if (r_state == IDLE && w_found) begin
        r_grant <= NUM_MASTERS'(1) << w_nidx;
        r_gidx  <= w_nidx;
        r_last  <= w_nidx;
      end else if (w_state_nx == IDLE) begin
        r_grant <= '0;
      end
    end
  end

  always_comb begin
    o_wb_cyc = 1'b0;
    o_wb_stb = 1'b0;
    o_wb_wen = 1'b0;
    o_wb_sel = '0;
    o_wb_adr = '0;
    o_wb_dat = '0;
    o_wb_cti = 3'b000;
    o_m_ack  = '0;
    if (r_state == OWN) begin
      o_wb_cyc = w_cyc_g;
      o_wb_stb = i_m_stb[r_gidx];
      o_wb_wen = i_m_wen[r_gidx];
      o_wb_sel = i_m_sel[4*r_gidx +: 4];
      o_wb_adr = i_m_adr[32*r_gidx +: 32];
      o_wb_dat = i_m_dat[32*r_gidx +: 32];
      o_wb_cti = i_m_cti[3*r_gidx +: 3];
      o_m_ack  = i_wb_ack ? r_grant : '0;
    end
  end

  assign o_m_dat = i_wb_dat;
  assign o_grant = r_grant;

endmodule

// File: tb/tb_zap_wb_arbiter.sv
// Directed bench for zap_wb_arbiter (4 masters, TIMEOUT_CYCLES=8).
// Watchdog checks follow ZAP_WB_ARBITER_TIMEOUT_EN.
module tb_zap_wb_arbiter;

  localparam int unsigned N = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  m_cyc = '0;
  logic [N-1:0]  m_stb;
  logic [N-1:0]  m_wen;
  logic [4*N-1:0]  m_sel;
  logic [32*N-1:0] m_adr;
  logic [32*N-1:0] m_dat;
  logic [3*N-1:0]  m_cti;
  logic [N-1:0]  m_ack, m_err, grant;
  logic [31:0]   m_rdat;
  logic          wb_cyc, wb_stb, wb_wen;
  logic [3:0]    wb_sel;
  logic [31:0]   wb_adr, wb_dat;
  logic [2:0]    wb_cti;
  logic [31:0]   wb_rdat = '0;
  logic          wb_ack = 1'b0;

  int unsigned errors = 0;
  int unsigned checks = 0;

  assign m_stb = m_cyc;

  zap_wb_arbiter #(.NUM_MASTERS(N), .TIMEOUT_CYCLES(8)) dut (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_m_cyc(m_cyc), .i_m_stb(m_stb), .i_m_wen(m_wen), .i_m_sel(m_sel),
    .i_m_adr(m_adr), .i_m_dat(m_dat), .i_m_cti(m_cti),
    .o_m_ack(m_ack), .o_m_err(m_err), .o_m_dat(m_rdat),
    .o_wb_cyc(wb_cyc), .o_wb_stb(wb_stb), .o_wb_wen(wb_wen), .o_wb_sel(wb_sel),
    .o_wb_adr(wb_adr), .o_wb_dat(wb_dat), .o_wb_cti(wb_cti),
    .i_wb_dat(wb_rdat), .i_wb_ack(wb_ack), .o_grant(grant)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cti(input int unsigned k, input logic [2:0] v);
    m_cti[3*k +: 3] = v;
  endtask

  initial begin
    for (int k = 0; k < N; k++) begin
      m_adr[32*k +: 32] = 32'h1000_0000 + 32'(k);
      m_dat[32*k +: 32] = 32'hD000_0000 + 32'(k);
      m_sel[4*k +: 4]   = 4'(k + 1);
      m_wen[k]          = k[0];
    end
    m_cti = '0;

    // reset state
    #12;
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_cyc", 32'(wb_cyc), 32'h0);
    check("rst_err", 32'(m_err), 32'h0);
    check("rst_adr", wb_adr, 32'h0);
    tick();
    rst_n = 1'b1;

    // masters 0 and 2 together: 0 first, then 2 after one idle cycle
    m_cyc = 4'b0101;
    #1 check("t34_pre", 32'(grant), 32'h0);
    tick();
    check("t34_g0", 32'(grant), 32'h1);
    check("t34_cyc", 32'(wb_cyc), 32'h1);
    check("t34_adr", wb_adr, 32'h1000_0000);
    wb_ack = 1'b1; wb_rdat = 32'hCAFE_0001;
    #1 check("t34_ack", 32'(m_ack), 32'h1);
    check("t34_rdat", m_rdat, 32'hCAFE_0001);
    tick();
    wb_ack = 1'b0; m_cyc[0] = 1'b0;
    #1 check("t34_drop", 32'(wb_cyc), 32'h0);
    tick();
    check("t34_idle", 32'(grant), 32'h0);
    tick();
    check("t34_g2", 32'(grant), 32'h4);
    check("t34_sel", 32'(wb_sel), 32'h3);
    check("t34_dat", wb_dat, 32'hD000_0002);
    m_cyc = '0;
    tick();

    // fresh pointer, all four contend: 0,1,2,3,0
    rst_n = 1'b0; #1 rst_n = 1'b1;
    m_cyc = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      int unsigned g;
      g = i % 4;
      tick();
      check("t35_grant", 32'(grant), 32'h1 << g);
      check("t35_wen", 32'(wb_wen), 32'(g % 2));
      wb_ack = 1'b1;
      #1 check("t35_ack", 32'(m_ack), 32'h1 << g);
      tick();
      wb_ack = 1'b0; m_cyc[g] = 1'b0;
      tick();
      check("t35_idle", 32'(grant), 32'h0);
      m_cyc[g] = 1'b1;
    end
    m_cyc = '0;
    tick();

    // master 1 burst while master 3 waits (last grant = 0)
    m_cyc = 4'b1010;
    tick();
    check("t36_g1", 32'(grant), 32'h2);
    for (int b = 0; b < 4; b++) begin
      set_cti(1, (b == 3) ? 3'b111 : 3'b010);
      wb_ack = 1'b1;
      #1 check("t36_cti", 32'(wb_cti), (b == 3) ? 32'h7 : 32'h2);
      check("t36_ack", 32'(m_ack), 32'h2);
      tick();
    end
    wb_ack = 1'b0; m_cyc[1] = 1'b0; set_cti(1, 3'b000);
    tick();
    check("t36_idle", 32'(grant), 32'h0);
    tick();
    check("t36_g3", 32'(grant), 32'h8);
    m_cyc = '0;
    tick();

    // reset mid-burst of master 2
    m_cyc = 4'b0100;
    tick();
    check("t37_g2", 32'(grant), 32'h4);
    set_cti(2, 3'b010); wb_ack = 1'b1;
    tick();
    rst_n = 1'b0;
    #1 check("t37_cyc", 32'(wb_cyc), 32'h0);
    check("t37_grant", 32'(grant), 32'h0);
    check("t37_ack", 32'(m_ack), 32'h0);
    check("t37_stb", 32'(wb_stb), 32'h0);
    wb_ack = 1'b0; m_cyc = 4'b1000; set_cti(2, 3'b000);
    tick();
    check("t37_held", 32'(grant), 32'h0);
    rst_n = 1'b1;
    tick();
    check("t37_g3", 32'(grant), 32'h8);
    m_cyc = '0;
    tick();

    // master 0 stalls with no ack
    m_cyc = 4'b0001;
    tick();
    check("t38_g0", 32'(grant), 32'h1);
`ifdef ZAP_WB_ARBITER_TIMEOUT_EN
    for (int c = 1; c < 8; c++) begin
      check("t38_noerr", 32'(m_err), 32'h0);
      tick();
    end
    check("t38_err", 32'(m_err), 32'h1);
    tick();
    check("t38_errpulse", 32'(m_err), 32'h0);
    check("t38_cyc", 32'(wb_cyc), 32'h0);
    tick(); tick();
    check("t38_masked", 32'(grant), 32'h0);
    m_cyc = '0;
    tick();
    m_cyc = 4'b0001;
    tick();
    check("t38_regrant", 32'(grant), 32'h1);
`else
    for (int c = 0; c < 105; c++) tick();
    check("t38_persist", 32'(grant), 32'h1);
    check("t38_cyc", 32'(wb_cyc), 32'h1);
    check("t38_err", 32'(m_err), 32'h0);
`endif
    m_cyc = '0;
    tick();
    check("end_idle", 32'(grant), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
